// File: rtl/turbo_pkg.sv
// Shared definitions for the turbo QPP interleaver address generator:
// default widths, FSM encoding and the conditional-subtract modular add.
package turbo_pkg;

    localparam int QPP_LEN_W  = 13;
    localparam int QPP_ADDR_W = 13;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2
    } qpp_state_t;

    // (a + b) mod k for a, b < k: one extra bit of headroom, one conditional subtract.
    function automatic logic [QPP_LEN_W-1:0] mod_add_k(
        input logic [QPP_LEN_W-1:0] a,
        input logic [QPP_LEN_W-1:0] b,
        input logic [QPP_LEN_W-1:0] k
    );
        logic [QPP_LEN_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, k}) begin
            s = s - {1'b0, k};
        end
        return s[QPP_LEN_W-1:0];
    endfunction

endpackage

// File: rtl/mod_add.sv
// Combinational (a + b) mod k, valid only when both operands are already < k.
module mod_add #(
    parameter int W = 13
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] k,
    output logic [W-1:0] sum
);

    logic [W:0] raw;
    logic [W:0] red;

    assign raw = {1'b0, a} + {1'b0, b};
    assign red = raw - {1'b0, k};
    assign sum = (raw >= {1'b0, k}) ? red[W-1:0] : raw[W-1:0];

endmodule

// File: rtl/turbo_qpp_addr_gen.sv
// QPP interleaver address generator: pi(i) = (f1*i + f2*i^2) mod K, produced
// incrementally with two modular adders and streamed out under valid/ready.
module turbo_qpp_addr_gen
    import turbo_pkg::*;
#(
    parameter int LEN_W  = QPP_LEN_W,
    parameter int ADDR_W = QPP_ADDR_W,
    parameter int IDX_W  = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  m_len,
    input  logic [LEN_W-1:0]  f1,
    input  logic [LEN_W-1:0]  f2,
    output logic              busy,
    output logic [ADDR_W-1:0] addr,
    output logic              addr_valid,
    input  logic              addr_ready,
    output logic              last,
    output logic              done,
    output logic              err
);

    qpp_state_t state;
    qpp_state_t state_next;

    logic [LEN_W-1:0] k_r;
    logic [LEN_W-1:0] f1_r;
    logic [LEN_W-1:0] f2_r;
    logic [LEN_W-1:0] pi_r;
    logic [LEN_W-1:0] g_r;
    logic [LEN_W-1:0] d_r;
    logic [LEN_W-1:0] pi_nxt;
    logic [LEN_W-1:0] g_nxt;
    logic [LEN_W-1:0] k_last;
    logic [IDX_W-1:0] idx_r;
    logic             done_r;
    logic             err_r;
    logic             start_bad;
    logic             hs;

    assign start_bad = (m_len < LEN_W'(2)) || (f1 >= m_len) || (f2 >= m_len);
    assign k_last    = k_r - LEN_W'(1);

    assign addr = pi_r;
    assign done = done_r;
    assign err  = err_r;

    // pi(i+1) = pi(i) + g(i) and g(i+1) = g(i) + d, both modulo K
    mod_add #(.W(LEN_W)) u_pi_add (
        .a   (pi_r),
        .b   (g_r),
        .k   (k_r),
        .sum (pi_nxt)
    );

    mod_add #(.W(LEN_W)) u_g_add (
        .a   (g_r),
        .b   (d_r),
        .k   (k_r),
        .sum (g_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        addr_valid = 1'b0;
        last       = 1'b0;
        hs         = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !start_bad) begin
                    state_next = ST_INIT;
                end
            end
            ST_INIT: begin
                busy       = 1'b1;
                state_next = ST_RUN;
            end
            ST_RUN: begin
                busy       = 1'b1;
                addr_valid = 1'b1;
                last       = (idx_r == IDX_W'(k_last));
                hs         = addr_ready;
                if (hs && last) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k_r    <= '0;
            f1_r   <= '0;
            f2_r   <= '0;
            pi_r   <= '0;
            g_r    <= '0;
            d_r    <= '0;
            idx_r  <= '0;
            done_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (start_bad) begin
                            err_r <= 1'b1;
                        end else begin
                            k_r  <= m_len;
                            f1_r <= f1;
                            f2_r <= f2;
                        end
                    end
                end
                ST_INIT: begin
                    g_r   <= mod_add_k(f1_r, f2_r, k_r);
                    d_r   <= mod_add_k(f2_r, f2_r, k_r);
                    pi_r  <= '0;
                    idx_r <= '0;
                end
                ST_RUN: begin
                    if (hs) begin
                        if (last) begin
                            done_r <= 1'b1;
                        end else begin
                            pi_r  <= pi_nxt;
                            g_r   <= g_nxt;
                            idx_r <= idx_r + IDX_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_turbo_qpp_addr_gen.sv
// Bench for turbo_qpp_addr_gen: table of configurations plus randomized ones,
// checked against a direct evaluation of (f1*i + f2*i^2) mod K.
module tb_turbo_qpp_addr_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [12:0] m_len;
    logic [12:0] f1;
    logic [12:0] f2;
    logic        busy;
    logic [12:0] addr;
    logic        addr_valid;
    logic        addr_ready;
    logic        last;
    logic        done;
    logic        err;

    int total = 0;
    int bad   = 0;

    bit seen [8192];

    typedef struct {
        int k;
        int f1;
        int f2;
        bit rnd;
        int inj;
        bit perm;
        bit exp_err;
    } vec_t;

    vec_t vecs [$];

    always #5 clk = ~clk;

    turbo_qpp_addr_gen dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .m_len      (m_len),
        .f1         (f1),
        .f2         (f2),
        .busy       (busy),
        .addr       (addr),
        .addr_valid (addr_valid),
        .addr_ready (addr_ready),
        .last       (last),
        .done       (done),
        .err        (err)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int qpp_ref(input int k, input int f1v, input int f2v, input int i);
        longint v;
        v = longint'(f1v) * longint'(i) + longint'(f2v) * longint'(i) * longint'(i);
        return int'(v % longint'(k));
    endfunction

    task automatic reject_start(input int k, input int f1v, input int f2v);
        start = 1'b1;
        m_len = 13'(k);
        f1    = 13'(f1v);
        f2    = 13'(f2v);
        step();
        start = 1'b0;
        chk("rej_err", err, 1);
        chk("rej_busy", busy, 0);
        chk("rej_valid", addr_valid, 0);
        step();
        chk("rej_err_fall", err, 0);
        chk("rej_busy2", busy, 0);
        chk("rej_valid2", addr_valid, 0);
    endtask

    // Ends in the cycle right after the last handshake (done cycle) unless rst_at fires.
    task automatic run_seq(input int k, input int f1v, input int f2v, input bit rnd,
                           input int inj, input bit perm, input int rst_at);
        int          i        = 0;
        int          cyc      = 0;
        int          distinct = 0;
        bit          stalled  = 1'b0;
        bit          rst_hit  = 1'b0;
        bit          rdy;
        logic [12:0] hold_addr;
        logic        hold_last;

        start = 1'b1;
        m_len = 13'(k);
        f1    = 13'(f1v);
        f2    = 13'(f2v);
        step();
        start = 1'b0;
        m_len = 13'($urandom);
        f1    = 13'($urandom);
        f2    = 13'($urandom);
        chk("init_busy", busy, 1);
        chk("init_valid", addr_valid, 0);
        step();
        chk("first_valid", addr_valid, 1);
        foreach (seen[j]) seen[j] = 1'b0;
        while (i < k && cyc < 8 * k + 64) begin
            chk("run_state", {busy, addr_valid, err}, 3'b110);
            chk("addr", addr, qpp_ref(k, f1v, f2v, i));
            chk("last", last, (i == k - 1) ? 1 : 0);
            if (stalled) begin
                chk("hold_addr", addr, hold_addr);
                chk("hold_last", last, hold_last);
            end
            if (i == rst_at) begin
                rst_hit = 1'b1;
                break;
            end
            rdy        = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            addr_ready = rdy;
            start      = (i == inj);
            if (rdy) begin
                if (!seen[addr]) distinct++;
                seen[addr] = 1'b1;
                i++;
                stalled = 1'b0;
            end else begin
                stalled   = 1'b1;
                hold_addr = addr;
                hold_last = last;
            end
            step();
            cyc++;
            start = 1'b0;
        end
        if (rst_hit) begin
            rst = 1'b1;
            step();
            rst = 1'b0;
            chk("rst_busy", busy, 0);
            chk("rst_valid", addr_valid, 0);
            chk("rst_addr", addr, 0);
            chk("rst_last", last, 0);
            chk("rst_done", done, 0);
            chk("rst_err", err, 0);
            step();
            chk("rst_no_done", done, 0);
            chk("rst_idle_valid", addr_valid, 0);
        end else if (i < k) begin
            chk("timeout_count", i, k);
        end else begin
            chk("done_pulse", done, 1);
            chk("busy_after", busy, 0);
            chk("valid_after", addr_valid, 0);
            if (!rnd) chk("cycles", cyc, k);
            if (perm) chk("distinct", distinct, k);
        end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        addr_ready = 1'b1;
        m_len      = '0;
        f1         = '0;
        f2         = '0;
        repeat (3) step();
        chk("reset_busy", busy, 0);
        chk("reset_valid", addr_valid, 0);
        chk("reset_addr", addr, 0);
        chk("reset_last", last, 0);
        chk("reset_done", done, 0);
        chk("reset_err", err, 0);
        rst = 1'b0;
        step();

        //               k     f1   f2   rnd  inj perm err
        vecs.push_back('{40,   3,   10,  1'b0, -1, 1'b1, 1'b0});
        vecs.push_back('{40,   3,   10,  1'b1, -1, 1'b1, 1'b0});
        vecs.push_back('{6144, 263, 480, 1'b0, -1, 1'b1, 1'b0});
        vecs.push_back('{1,    0,   0,   1'b0, -1, 1'b0, 1'b1});
        vecs.push_back('{40,   3,   40,  1'b0, -1, 1'b0, 1'b1});
        vecs.push_back('{40,   40,  3,   1'b0, -1, 1'b0, 1'b1});
        vecs.push_back('{0,    0,   0,   1'b0, -1, 1'b0, 1'b1});
        vecs.push_back('{248,  33,  62,  1'b1, -1, 1'b1, 1'b0});
        vecs.push_back('{2,    1,   0,   1'b1, -1, 1'b1, 1'b0});
        vecs.push_back('{40,   3,   10,  1'b0, 5,  1'b1, 1'b0});

        foreach (vecs[n]) begin
            if (vecs[n].exp_err) begin
                reject_start(vecs[n].k, vecs[n].f1, vecs[n].f2);
            end else begin
                run_seq(vecs[n].k, vecs[n].f1, vecs[n].f2, vecs[n].rnd,
                        vecs[n].inj, vecs[n].perm, -1);
                addr_ready = 1'b1;
                step();
                chk("done_fall", done, 0);
            end
        end

        run_seq(40, 3, 10, 1'b0, -1, 1'b1, 17);
        run_seq(40, 3, 10, 1'b0, -1, 1'b1, -1);
        run_seq(248, 33, 62, 1'b1, -1, 1'b1, -1);
        addr_ready = 1'b1;
        step();
        chk("done_fall_chain", done, 0);

        for (int r = 0; r < 6; r++) begin
            int k;
            int a;
            int b;
            k = int'($urandom_range(2, 300));
            a = int'($urandom_range(0, k - 1));
            b = int'($urandom_range(0, k - 1));
            run_seq(k, a, b, 1'b1, -1, 1'b0, -1);
            addr_ready = 1'b1;
            step();
            chk("done_fall_rand", done, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
